// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and stalls on the memory-ready handshake.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic pc_write;
  logic pc_write_cond;
  logic ir_write_d;
  logic reg_write_d;
  logic mem_write_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state     = cur_state;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write_d   = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_d = mem_ready;
        pc_write   = mem_ready;
        nxt_state  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target PC + (imm << 2) is computed here speculatively.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_ADDI:      nxt_state = S_ADDIEX;
          OP_J:         nxt_state = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            nxt_state  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        ior_d     = 1'b1;
        nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_d = 1'b1;
        mem_to_reg  = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_d = 1'b1;
        ior_d       = 1'b1;
        nxt_state   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt_state = S_RWB;
      end
      S_RWB: begin
        reg_write_d = 1'b1;
        reg_dst     = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        nxt_state     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_d = 1'b1;
        nxt_state   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  // Write enables are masked by rst_n directly so nothing commits while reset is low.
  assign pc_en     = rst_n & (pc_write | (pc_write_cond & zero));
  assign ir_write  = rst_n & ir_write_d;
  assign reg_write = rst_n & reg_write_d;
  assign mem_write = rst_n & mem_write_d;
  assign state     = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed instruction sequences with
// hand-written per-cycle expectations checked by an independent monitor.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ior_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Field order: pc_en ior_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source illegal_op
  localparam logic [15:0] O_FETCH  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_FSTALL = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_DECI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [15:0] O_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_MEMRD  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_MEMWR  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [15:0] O_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_BR1    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [15:0] O_BR0    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [15:0] O_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] O_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};

  typedef struct {
    logic [3:0]  st;
    logic [15:0] o;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic probe    = 1'b0;

  logic [15:0] act;
  assign act = {pc_en, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  always begin
    @(negedge clk or posedge probe);
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if ({state, act} !== {e.st, e.o}) begin
        n_fail++;
        $display("FAIL %s: got state=%0d outs=%b, required state=%0d outs=%b",
                 e.name, state, act, e.st, e.o);
      end
    end
  end

  task automatic push(input logic [3:0] st, input logic [15:0] o, input string name);
    exp_t e;
    e.st = st; e.o = o; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] st, input logic [15:0] o, input string name);
    push(st, o, name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step(4'd0, O_FSTALL, "reset_hold");
    rst_n = 1'b1;

    opcode = 6'b100011;
    step(4'd0, O_FETCH,  "lw_fetch");
    step(4'd1, O_DEC,    "lw_decode");
    step(4'd2, O_MEMADR, "lw_memadr");
    step(4'd3, O_MEMRD,  "lw_memrd");
    step(4'd4, O_MEMWB,  "lw_memwb");

    opcode = 6'b000000;
    step(4'd0, O_FETCH, "r_fetch");
    step(4'd1, O_DEC,   "r_decode");
    step(4'd6, O_EXEC,  "r_exec");
    step(4'd7, O_RWB,   "r_rwb");

    opcode = 6'b101011;
    step(4'd0, O_FETCH,  "sw_fetch");
    step(4'd1, O_DEC,    "sw_decode");
    step(4'd2, O_MEMADR, "sw_memadr");
    mem_ready = 1'b0;
    step(4'd5, O_MEMWR,  "sw_memwr_stall1");
    step(4'd5, O_MEMWR,  "sw_memwr_stall2");
    mem_ready = 1'b1;
    step(4'd5, O_MEMWR,  "sw_memwr_done");

    opcode = 6'b000100; zero = 1'b1;
    step(4'd0, O_FETCH, "beq1_fetch");
    step(4'd1, O_DEC,   "beq1_decode");
    step(4'd8, O_BR1,   "beq_taken");
    zero = 1'b0;
    step(4'd0, O_FETCH, "beq0_fetch");
    step(4'd1, O_DEC,   "beq0_decode");
    step(4'd8, O_BR0,   "beq_not_taken");

    opcode = 6'b001000; mem_ready = 1'b0;
    step(4'd0, O_FSTALL, "fetch_stall1");
    step(4'd0, O_FSTALL, "fetch_stall2");
    step(4'd0, O_FSTALL, "fetch_stall3");
    mem_ready = 1'b1;
    step(4'd0, O_FETCH,  "fetch_release");
    step(4'd1, O_DEC,    "addi_decode");
    step(4'd9, O_MEMADR, "addi_ex");
    step(4'd10, O_ADDIWB, "addi_wb");

    opcode = 6'b100011;
    step(4'd0, O_FETCH,  "lw2_fetch");
    step(4'd1, O_DEC,    "lw2_decode");
    step(4'd2, O_MEMADR, "lw2_memadr");
    mem_ready = 1'b0;
    step(4'd3, O_MEMRD,  "lw2_memrd_stall");
    mem_ready = 1'b1;
    step(4'd3, O_MEMRD,  "lw2_memrd_done");
    step(4'd4, O_MEMWB,  "lw2_memwb");

    opcode = 6'b111111;
    step(4'd0, O_FETCH, "ill_fetch");
    step(4'd1, O_DECI,  "ill_decode");
    opcode = 6'b000010;
    step(4'd0, O_FETCH, "j_fetch");
    step(4'd1, O_DEC,   "j_decode");
    step(4'd11, O_JUMP, "j_jump");

    opcode = 6'b000000;
    step(4'd0, O_FETCH, "rst_r_fetch");
    step(4'd1, O_DEC,   "rst_r_decode");
    push(4'd6, O_EXEC,  "rst_r_exec");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    push(4'd0, O_FSTALL, "async_reset_mid_exec");
    probe = 1'b1; #1; probe = 1'b0;
    @(posedge clk); #1;
    step(4'd0, O_FSTALL, "reset_held");
    rst_n = 1'b1;
    step(4'd0, O_FETCH, "post_reset_fetch");
    step(4'd1, O_DEC,   "post_reset_decode");

    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including the 2-bit `alu_op` that the ALU control stage consumes. It also stalls on a memory-ready handshake.

## Interface
Parameters:
- none (opcode and state encodings are fixed as listed below)

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction register bits [31:26]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_en`  out  1  PC load enable: `pc_write | (pc_write_cond & zero)`
- `ior_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  write-back data select: 1 = MDR
- `reg_dst`  out  1  destination register select: 1 = rd, 0 = rt
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A register
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = use funct field
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode
- `state`  out  4  current FSM state (debug)

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and return to FETCH.
- Outputs are Moore outputs decoded from `state`; `mem_ready` and `zero` are the only inputs that gate them. Any output not listed for a state is 0.
- FETCH
  - `mem_read`=1, `ior_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE
  - `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - Next state by opcode: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, addi → ADDIEX, j → JUMP.
  - Any other opcode → FETCH with `illegal_op`=1 during DECODE.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00; lw → MEMRD, sw → MEMWR.
- MEMRD: `mem_read`=1, `ior_d`=1; holds until `mem_ready`, then → MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; → FETCH.
- MEMWR: `mem_write`=1, `ior_d`=1; holds until `mem_ready`, then → FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10; → RWB.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write_cond`=1; → FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00; → ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; → FETCH.
- JUMP: `pc_source`=10, `pc_write`=1; → FETCH.
- `pc_write` and `pc_write_cond` are internal only; `pc_en` is their combined output.

## Timing
- Reset
  - `rst_n` low forces `state`=FETCH immediately, with no clock required.
  - While `rst_n`=0, `pc_en`, `ir_write`, `reg_write` and `mem_write` are forced to 0. All other outputs show FETCH decode: `mem_read`=1, `alu_src_b`=01, everything else 0.
  - Reset asserted mid-instruction abandons that instruction; no write enable is issued after the asynchronous assertion.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held stable during the stall.
- `mem_ready` is ignored in all other states.
- `pc_en` in BRANCH follows `zero` combinationally in the same cycle.
- `illegal_op` is high for exactly the one DECODE cycle of an unsupported opcode.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC without a clock edge → `state`=0 at once; `reg_write`=0, `pc_en`=0, `mem_read`=1.
- **lw:** `opcode`=100011, `mem_ready`=1 → state sequence 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in state 4; `ir_write`=1 only in state 0.
- **R-type then sw:** R-type gives 0,1,6,7,0 with `alu_op`=10 in state 6 only. sw with `mem_ready` low for 2 cycles in MEMWR → `mem_write` high for 3 cycles, then state returns to 0.
- **beq:** `zero`=1 → `pc_en`=1 and `pc_source`=01 in state 8. `zero`=0 → `pc_en`=0 in state 8.
- **Fetch stall:** `mem_ready`=0 for 3 cycles in FETCH → state holds at 0 and `pc_en`=`ir_write`=0. On the 4th cycle `mem_ready`=1 → both enables are 1, then state 1.
- **Illegal opcode and j:** `opcode`=111111 → `illegal_op` pulses once in DECODE, next state 0. `opcode`=000010 → states 0,1,11,0 with `pc_source`=10 and `pc_en`=1 in state 11.
